// File: rtl/xfade_seq.sv
// rtl/xfade_seq.sv - crossfade sequencer driving the two-voice gain stage mode strobes and gain words
//
// Steps GAIN1/GAIN2 in complementary amounts on the sample tick so the gain
// stage fades from voice KA to KB and back. The four mode strobes are one-hot.
// With XFADE_AUTO_EN defined, the sequencer also swaps on its own after
// HOLD_TICKS ticks in a steady state. Without it, only req starts a fade.
//
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   tick   in   sample-rate strobe, one cycle wide
//   req    in   swap-source request, one-cycle pulse
//   A      out  steady on voice KA
//   AB     out  fading KA->KB
//   B      out  steady on voice KB
//   BA     out  fading KB->KA
//   GAIN1  out  KA gain word, 0..127
//   GAIN2  out  KB gain word, always 127-GAIN1
//   busy   out  fade in progress (AB|BA)
//   done   out  one-cycle pulse on the step that completes a fade

module xfade_seq #(
    parameter int STEP       = 4,
    parameter int TICK_DIV   = 2,
    parameter int HOLD_TICKS = 48000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       req,
    output logic       A,
    output logic       AB,
    output logic       B,
    output logic       BA,
    output logic [6:0] GAIN1,
    output logic [6:0] GAIN2,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_A  = 2'd0,
        ST_AB = 2'd1,
        ST_B  = 2'd2,
        ST_BA = 2'd3
    } state_t;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX   = PW'(TICK_DIV - 1);
    localparam logic [6:0]    STEP7     = 7'(STEP);
    localparam logic [6:0]    GAIN_FULL = 7'd127;
    // In a KB->KA fade, any GAIN1 at or above this saturates on the next step.
    localparam logic [6:0]    BA_LIMIT  = GAIN_FULL - STEP7;

    if (STEP < 1 || STEP > 127) begin : g_bad_step
        $error("xfade_seq: STEP must be 1..127");
    end
    if (TICK_DIV < 1) begin : g_bad_div
        $error("xfade_seq: TICK_DIV must be >= 1");
    end
    if (HOLD_TICKS < 1) begin : g_bad_hold
        $error("xfade_seq: HOLD_TICKS must be >= 1");
    end

    state_t          state;
    state_t          state_nxt;
    logic [6:0]      gain1_nxt;
    logic            pending;
    logic            pending_nxt;
    logic [PW-1:0]   pre;
    logic [PW-1:0]   pre_nxt;
    logic            done_nxt;
    logic            step_now;
    logic            req_any;

`ifdef XFADE_AUTO_EN
    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS - 1);

    logic [HW-1:0] hold_cnt;
    logic          steady;
    logic          auto_req;

    assign steady   = (state == ST_A) || (state == ST_B);
    assign auto_req = steady && tick && (hold_cnt == HOLD_MAX);
    assign req_any  = req | auto_req;

    // Dwell counter: runs only in steady states and restarts on every state
    // change, so each steady visit gets a full HOLD_TICKS dwell.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (state_nxt != state || !steady || auto_req) begin
            hold_cnt <= '0;
        end else if (tick) begin
            hold_cnt <= hold_cnt + HW'(1);
        end
    end
`else
    assign req_any = req;
`endif

    // A step happens on the tick that wraps the prescaler.
    assign step_now = tick && (pre == PRE_MAX);

    always_comb begin
        state_nxt   = state;
        gain1_nxt   = GAIN1;
        pending_nxt = pending;
        pre_nxt     = pre;
        done_nxt    = 1'b0;

        case (state)
            ST_A: begin
                if (req_any) begin
                    state_nxt = ST_AB;
                    pre_nxt   = '0;
                end
            end

            ST_B: begin
                if (req_any) begin
                    state_nxt = ST_BA;
                    pre_nxt   = '0;
                end
            end

            ST_AB: begin
                if (tick) begin
                    pre_nxt = step_now ? '0 : pre + PW'(1);
                end
                if (step_now) begin
                    if (GAIN1 <= STEP7) begin
                        gain1_nxt = 7'd0;
                        done_nxt  = 1'b1;
                        // A request arriving on the completing step counts
                        // as pending, so the reverse fade starts at once.
                        if (pending || req_any) begin
                            state_nxt   = ST_BA;
                            pending_nxt = 1'b0;
                            pre_nxt     = '0;
                        end else begin
                            state_nxt = ST_B;
                        end
                    end else begin
                        gain1_nxt = GAIN1 - STEP7;
                    end
                end
                if (!done_nxt && req_any) begin
                    pending_nxt = 1'b1;
                end
            end

            ST_BA: begin
                if (tick) begin
                    pre_nxt = step_now ? '0 : pre + PW'(1);
                end
                if (step_now) begin
                    if (GAIN1 >= BA_LIMIT) begin
                        gain1_nxt = GAIN_FULL;
                        done_nxt  = 1'b1;
                        if (pending || req_any) begin
                            state_nxt   = ST_AB;
                            pending_nxt = 1'b0;
                            pre_nxt     = '0;
                        end else begin
                            state_nxt = ST_A;
                        end
                    end else begin
                        gain1_nxt = GAIN1 + STEP7;
                    end
                end
                if (!done_nxt && req_any) begin
                    pending_nxt = 1'b1;
                end
            end

            default: begin
                state_nxt = ST_A;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_A;
            pending <= 1'b0;
            pre     <= '0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            pre     <= pre_nxt;
        end
    end

    // Outputs are decoded from the next state and registered, so they change
    // in the same clock as the state register and are glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            A     <= 1'b1;
            AB    <= 1'b0;
            B     <= 1'b0;
            BA    <= 1'b0;
            GAIN1 <= GAIN_FULL;
            GAIN2 <= 7'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            A     <= (state_nxt == ST_A);
            AB    <= (state_nxt == ST_AB);
            B     <= (state_nxt == ST_B);
            BA    <= (state_nxt == ST_BA);
            GAIN1 <= gain1_nxt;
            GAIN2 <= GAIN_FULL - gain1_nxt;
            busy  <= (state_nxt == ST_AB) || (state_nxt == ST_BA);
            done  <= done_nxt;
        end
    end

endmodule

// File: tb/tb_xfade_seq.sv
// tb/tb_xfade_seq.sv - self-checking bench for xfade_seq against a tick-count reference model

module tb_xfade_seq;

    localparam int STEP       = 4;
    localparam int TICK_DIV   = 2;
    localparam int NSTEPS     = (127 + STEP - 1) / STEP;
    localparam int FADE_TICKS = NSTEPS * TICK_DIV;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic       req;
    logic       A, AB, B, BA;
    logic [6:0] GAIN1, GAIN2;
    logic       busy, done;

    int tests = 0;
    int fails = 0;

    // Reference model: where the voice is (or fades from), whether a fade is
    // running, and how many ticks of that fade have elapsed.
    bit m_src_b;
    bit m_fading;
    bit m_pending;
    bit m_done;
    int m_n;

    xfade_seq #(.STEP(STEP), .TICK_DIV(TICK_DIV), .HOLD_TICKS(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick),
        .req   (req),
        .A     (A),
        .AB    (AB),
        .B     (B),
        .BA    (BA),
        .GAIN1 (GAIN1),
        .GAIN2 (GAIN2),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_src_b   = 1'b0;
        m_fading  = 1'b0;
        m_pending = 1'b0;
        m_done    = 1'b0;
        m_n       = 0;
    endtask

    // Advance the model by one clock with the given inputs.
    task automatic model_step(input bit r, input bit t);
        m_done = 1'b0;
        if (!m_fading) begin
            if (r) begin
                m_fading  = 1'b1;
                m_n       = 0;
                m_pending = 1'b0;
            end
        end else begin
            if (t) m_n++;
            if (m_n == FADE_TICKS) begin
                m_done  = 1'b1;
                m_src_b = !m_src_b;
                m_n     = 0;
                if (m_pending || r) begin
                    m_pending = 1'b0;
                end else begin
                    m_fading = 1'b0;
                end
            end else if (r) begin
                m_pending = 1'b1;
            end
        end
    endtask

    function automatic int exp_gain1();
        int k;
        if (!m_fading) return m_src_b ? 0 : 127;
        k = (m_n / TICK_DIV) * STEP;
        if (!m_src_b) return (127 - k < 0) ? 0 : 127 - k;
        return (k > 127) ? 127 : k;
    endfunction

    function automatic logic [3:0] exp_mode();
        if (!m_fading) return m_src_b ? 4'b0010 : 4'b1000;
        return m_src_b ? 4'b0001 : 4'b0100;
    endfunction

    task automatic check_all();
        chk("mode",  {28'd0, A, AB, B, BA}, {28'd0, exp_mode()});
        chk("gain1", {25'd0, GAIN1}, exp_gain1());
        chk("gain2", {25'd0, GAIN2}, 127 - exp_gain1());
        chk("busy",  {31'd0, busy}, {31'd0, m_fading});
        chk("done",  {31'd0, done}, {31'd0, m_done});
    endtask

    // One clock: check what the last edge produced, then present new inputs.
    task automatic cycle(input bit r, input bit t);
        @(negedge clk);
        check_all();
        req  = r;
        tick = t;
        model_step(r, t);
    endtask

    // Runs continuous ticks; optional req pulses on given tick indices.
    task automatic run_ticks(input int n, input int req_at1, input int req_at2);
        for (int i = 0; i < n; i++) begin
            cycle((i == req_at1) || (i == req_at2), 1'b1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        tick  = 1'b0;
        req   = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle: ticks without req leave the sequencer on KA.
        cycle(1'b0, 1'b0);
        run_ticks(10, -1, -1);

        // Full KA->KB fade, then KB->KA fade, continuous ticks.
        cycle(1'b1, 1'b0);
        run_ticks(FADE_TICKS + 6, -1, -1);
        chk("at_b", {31'd0, B}, 32'd1);
        cycle(1'b1, 1'b0);
        run_ticks(FADE_TICKS + 6, -1, -1);
        chk("at_a", {31'd0, A}, 32'd1);

        // Requests during a fade: one pending reverse fade only.
        cycle(1'b1, 1'b0);
        run_ticks(2 * FADE_TICKS + 10, 10, 20);
        chk("back_a", {31'd0, A}, 32'd1);

        // Request on the completing tick of a fade.
        cycle(1'b1, 1'b0);
        run_ticks(2 * FADE_TICKS + 10, FADE_TICKS - 1, -1);

        // Asynchronous reset mid-fade with a pending request.
        cycle(1'b1, 1'b0);
        run_ticks(30, 5, -1);
        @(negedge clk);
        check_all();
        chk("mid_gain1", {25'd0, GAIN1}, 32'd67);
        tick = 1'b0;
        req  = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        run_ticks(3 * FADE_TICKS, -1, -1);

        // Randomized phase.
        for (int i = 0; i < 4000; i++) begin
            cycle($urandom_range(0, 29) == 0, $urandom_range(0, 1) == 1);
        end
        @(negedge clk);
        check_all();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/xfade_seq.md
Name: xfade_seq

Overview:
- Crossfade sequencer that sits directly upstream of the two-voice gain stage in the Voice Corruptor path.
- Generates the one-hot mode strobes (A, AB, B, BA) and the 7-bit gain words GAIN1/GAIN2 that the gain stage consumes.
- Ramps GAIN1 and GAIN2 in complementary steps on the sample strobe, giving a timed fade from voice KA to KB and back.

Parameters:
- STEP, 4, gain decrement/increment per ramp step (1..127).
- TICK_DIV, 2, number of sample ticks per ramp step (>=1).
- HOLD_TICKS, 48000, dwell ticks in a steady state before an auto-swap; used only with XFADE_AUTO_EN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tick  in  1  sample-rate strobe, 1 cycle wide
- req  in  1  swap-source request, 1-cycle pulse
- A  out  1  steady on voice KA
- AB  out  1  fading KA->KB
- B  out  1  steady on voice KB
- BA  out  1  fading KB->KA
- GAIN1  out  7  KA gain, 0..127
- GAIN2  out  7  KB gain, 0..127
- busy  out  1  fade in progress (AB|BA)
- done  out  1  1-cycle pulse at fade completion

Behaviour:
- One clock; reset is asynchronous and active-low on rst_n.
- Reset values:
  - state=ST_A, A=1, AB=B=BA=0
  - GAIN1=127, GAIN2=0
  - busy=0, done=0, pending=0, prescaler=0
- All outputs are registered.
- Mode outputs are one-hot at all times; busy = AB|BA.
- States: ST_A, ST_AB, ST_B, ST_BA.
- ST_A + req: next cycle ST_AB, prescaler=0. Gains are unchanged on entry.
- ST_B + req: next cycle ST_BA, prescaler=0.
- Prescaler in the fade states, counted on tick only:
  - prescaler==TICK_DIV-1: prescaler<=0 and apply one step.
  - otherwise: prescaler++.
- Step in ST_AB:
  - GAIN1 <= max(GAIN1-STEP, 0); GAIN2 <= 127-new GAIN1.
  - GAIN1+GAIN2=127 is invariant in every cycle.
- Step in ST_BA: mirror of ST_AB. GAIN1 <= min(GAIN1+STEP, 127); GAIN2 <= 127-new GAIN1.
- Completion is the step that makes the target saturate (ST_AB: GAIN1 reaches 0; ST_BA: GAIN1 reaches 127). In that same clock:
  - state goes to ST_B (or ST_A), and done=1 for exactly one cycle.
  - If pending=1, state goes directly to the reverse fade (ST_BA / ST_AB) instead, pending<=0, prescaler<=0, and done still pulses.
- req while busy: pending<=1. The pending request is one-deep; further reqs are dropped.
- req in the same cycle as the completing step: counts as pending and starts the reverse fade.
- req and tick may coincide with any state; req in a steady state takes effect regardless of tick.
- Fade length: ceil(127/STEP) steps × TICK_DIV ticks.
- tick outside the fade states: no effect, except the auto-swap counter.
- Reset mid-fade returns immediately to the reset values; the pending request is lost.

Optional Feature:
- Macro: XFADE_AUTO_EN.
- Defined:
  - A hold counter counts ticks in ST_A/ST_B.
  - On reaching HOLD_TICKS-1 it raises an internal request, ORed with req, and clears.
  - The counter clears on every state entry and is held at 0 in the fade states.
- Undefined:
  - The counter logic is absent; transitions occur only on external req.
  - HOLD_TICKS is ignored.

Test Plan:
1. Reset then idle, 10 ticks, no req -> A=1, GAIN1=127, GAIN2=0, busy=0, done never asserted.
2. STEP=4, TICK_DIV=2; req in ST_A, then continuous ticks:
   - AB=1 the cycle after req.
   - GAIN1 sequence 127,123,…,7,3,0, changing every 2nd tick; GAIN2=127-GAIN1 every cycle.
   - After 64 ticks B=1, GAIN2=127, with one done pulse.
3. In ST_B, req -> BA=1; GAIN1 ramps 0,4,…,124,127; ends A=1 after 64 ticks with done pulse.
4. req at tick 10 of an AB fade, second req at tick 20 -> on completion done pulses, mode goes AB->BA directly, one reverse fade only, then ST_A.
5. rst_n low at tick 30 of an AB fade (GAIN1=67) -> asynchronously A=1, GAIN1=127, GAIN2=0, busy=0, pending cleared; no fade after release.
6. XFADE_AUTO_EN with HOLD_TICKS=8, no external req -> AB entered after 8 ticks in ST_A; after the fade, BA entered after 8 ticks in ST_B; continues alternating.
